// File: rtl/enc_binder_array_if.sv
// ============================================================================
// Module   : enc_binder_array_if
// Purpose  : Start/busy/done and hypervector bus between the level-HV lookup,
//            the binder array and the bundler.
//            Optional ch_mask signal present when ENC_BINDER_MASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enc_binder_array_if #(
  parameter int HV_DIM = 1024,
  parameter int NUM_CH = 10
);
  logic              start_encoding;
  logic              unbind;
  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1];
  logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1];
  logic              busy;
  logic              done;
  logic              out_valid;
`ifdef ENC_BINDER_MASK_EN
  logic [NUM_CH-1:0] ch_mask;

  modport master (
    output start_encoding, unbind, level_hv, ch_mask,
    input  shifted_hv, busy, done, out_valid
  );
  modport slave (
    input  start_encoding, unbind, level_hv, ch_mask,
    output shifted_hv, busy, done, out_valid
  );
`else
  modport master (
    output start_encoding, unbind, level_hv,
    input  shifted_hv, busy, done, out_valid
  );
  modport slave (
    input  start_encoding, unbind, level_hv,
    output shifted_hv, busy, done, out_valid
  );
`endif
endinterface

`default_nettype wire

// File: rtl/enc_binder_array.sv
// ============================================================================
// Module   : enc_binder_array
// Purpose  : Time-multiplexed circular rotator bank; LANES channels per cycle,
//            bind = rotate left, unbind = rotate right, by SHIFTS[SHIFT_BASE+c].
//            Define ENC_BINDER_MASK_EN to add the per-channel ch_mask input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_binder_array #(
  parameter int          HV_DIM     = 1024,
  parameter int          NUM_CH     = 10,
  parameter int          LANES      = 2,
  parameter int          SHIFT_BASE = 10,
  parameter int          NUM_SHIFTS = 20,
  parameter int unsigned SHIFTS [0:NUM_SHIFTS-1] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
    3, 17, 29, 41, 53, 67, 79, 97, 113, 131
  }
) (
  input  logic               clk,
  input  logic               rst,
  enc_binder_array_if.slave  bus
);

  localparam int NB = (NUM_CH + LANES - 1) / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [BW-1:0] LAST_BATCH = BW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((LANES < 1) || (LANES > NUM_CH) || (SHIFT_BASE + NUM_CH > NUM_SHIFTS)) begin : g_bad_cfg
    $fatal(1, "enc_binder_array: illegal LANES / SHIFT_BASE / SHIFTS configuration");
  end

  // Clamp keeps constant indices in range for lanes past the last channel.
  function automatic int chan_idx(input int c);
    return (c < NUM_CH) ? c : 0;
  endfunction

  function automatic logic [SW-1:0] eff_shift(input int c);
    return SW'(SHIFTS[SHIFT_BASE + c] % HV_DIM);
  endfunction

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [BW-1:0]     batch;
  logic              cap_unbind;
  logic [HV_DIM-1:0] cap_hv   [0:NUM_CH-1];
  logic [HV_DIM-1:0] out_hv   [0:NUM_CH-1];
  logic [HV_DIM-1:0] lane_out [0:LANES-1];
  logic              out_valid_q;
  logic [NUM_CH-1:0] ch_en;

`ifdef ENC_BINDER_MASK_EN
  logic [NUM_CH-1:0] cap_mask;
  assign ch_en = cap_mask;
`else
  assign ch_en = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start_encoding) state_nxt = S_RUN;
      S_RUN:   if (batch == LAST_BATCH) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == S_RUN);
    bus.done      = (state == S_DONE);
    bus.out_valid = out_valid_q;
  end

  // Each lane picks its channel for the current batch, then rotates it via a
  // doubled vector so any amount in [0, HV_DIM) is a true circular shift.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [HV_DIM-1:0]   sel_hv;
    logic [SW-1:0]       sel_sh;
    logic [2*HV_DIM-1:0] dbl;
    logic [2*HV_DIM-1:0] rot_l;
    logic [2*HV_DIM-1:0] rot_r;

    always_comb begin
      sel_hv = '0;
      sel_sh = '0;
      for (int b = 0; b < NB; b++) begin
        if ((b * LANES + k < NUM_CH) && (batch == BW'(b))) begin
          sel_hv = cap_hv[chan_idx(b * LANES + k)];
          sel_sh = eff_shift(chan_idx(b * LANES + k));
        end
      end
    end

    assign dbl         = {sel_hv, sel_hv};
    assign rot_l       = dbl << sel_sh;
    assign rot_r       = dbl >> sel_sh;
    assign lane_out[k] = cap_unbind ? rot_r[HV_DIM-1:0] : rot_l[2*HV_DIM-1:HV_DIM];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      batch       <= '0;
      cap_unbind  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ENC_BINDER_MASK_EN
      cap_mask    <= '0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
        cap_hv[c] <= '0;
        out_hv[c] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_encoding) begin
            cap_unbind  <= bus.unbind;
            batch       <= '0;
            out_valid_q <= 1'b0;
`ifdef ENC_BINDER_MASK_EN
            cap_mask    <= bus.ch_mask;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
              cap_hv[c] <= bus.level_hv[c];
            end
          end
        end
        S_RUN: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (batch == BW'(c / LANES)) begin
              out_hv[c] <= ch_en[c] ? lane_out[c % LANES] : '0;
            end
          end
          if (batch == LAST_BATCH) begin
            batch       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            batch <= batch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.shifted_hv = out_hv;

endmodule

`default_nettype wire

// File: doc/enc_binder_array.md
Name: enc_binder_array

Overview:
- Parametrised, time-multiplexed binder array for the sparse HDC encoder.
- Captures NUM_CH level hypervectors on start, then circularly rotates each by its channel shift from the shared SHIFTS table, LANES channels per cycle.
- Supports a bind (rotate-left) mode and an unbind (rotate-right) mode.
- Sits between the level-HV lookup and the bundler, with a start/busy/done handshake and held registered outputs.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- NUM_CH, 10, number of channels.
- LANES, 2, rotators instantiated and channels processed per cycle; legal range 1..NUM_CH.
- SHIFT_BASE, 10, channel i uses shift SHIFTS[SHIFT_BASE+i].

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, reset; synchronous, active-high.
- start_encoding, in, 1, start request; honoured only in IDLE.
- unbind, in, 1, mode: 0 = rotate left (bind), 1 = rotate right (unbind); sampled with start.
- level_hv, in, HV_DIM x NUM_CH (unpacked [0:NUM_CH-1]), input hypervectors; sampled with start.
- shifted_hv, out, HV_DIM x NUM_CH (unpacked [0:NUM_CH-1]), registered results.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse when all channels are written.
- out_valid, out, 1, shifted_hv is complete and coherent.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, batch counter=0.
  - shifted_hv all zero; busy=0, done=0, out_valid=0; capture registers zero.
  - rst overrides all other inputs, including mid-RUN; after reset the block waits for a fresh start.
- NB = ceil(NUM_CH/LANES).
- FSM:
  - IDLE: on start_encoding=1, capture level_hv and unbind, clear out_valid, batch=0, go RUN.
  - RUN: each cycle, for lanes k=0..LANES-1, channel c=batch*LANES+k. If c<NUM_CH, write shifted_hv[c]. Out-of-range lanes of the last partial batch write nothing.
  - RUN: batch increments; on the last batch (batch=NB-1) go DONE.
  - DONE: done=1, out_valid=1, busy=0 for this cycle; unconditionally go IDLE next edge.
- Latency:
  - start sampled at edge E0; batches written at edges E1..E_NB; done high for the cycle following E_NB.
  - Start-to-done = NB+1 cycles.
  - Next start accepted in the IDLE cycle after done; start is ignored during RUN and DONE.
- Rotation:
  - eff = SHIFTS[SHIFT_BASE+c] mod HV_DIM.
  - Bind: out = rotl(hv, eff). Unbind: out = rotr(hv, eff).
  - eff=0 passes the vector through.
  - Shift amounts >= HV_DIM wrap via the modulo; the result is never a partial or zero-filled shift.
- Outputs:
  - shifted_hv entries hold their values between runs.
  - During RUN, entries are a mix of old and new data; consumers must use out_valid or done.
  - out_valid stays high from DONE until the next accepted start or reset.
- Input changes on level_hv/unbind after E0 have no effect on the current run.
- Elaboration assertion: LANES<1, LANES>NUM_CH, or SHIFT_BASE+NUM_CH exceeding SHIFTS size is a fatal error.

Optional Feature:
- ENC_BINDER_MASK_EN defined:
  - Adds input ch_mask [NUM_CH-1:0], sampled with start.
  - Channels with mask bit 0 are written as all-zero in their batch slot.
  - Batch count and latency are unchanged.
- ENC_BINDER_MASK_EN undefined: port absent; all channels bound.

Test Plan:
- HV_DIM=16, NUM_CH=4, LANES=2, shifts {1,2,3,17}, all level_hv=16'h0001, unbind=0, start -> busy for 2 cycles; done pulse at start+3; shifted_hv={0002,0004,0008,0002}; out_valid=1.
- Same config with unbind=1 -> shifted_hv={8000,4000,2000,8000}; shift 17 behaves as 1.
- NUM_CH=4, LANES=3, shifts {1,1,1,1}, level_hv=16'h8001 -> NB=2; done at start+3; all outputs 16'h0003; no write beyond channel 3.
- start_encoding held high for 6 cycles, then a second start pulse while busy -> exactly one run per IDLE acceptance; captured inputs unchanged by mid-run level_hv changes.
- rst asserted on the cycle after the first batch write -> next edge all outputs 0, busy/done/out_valid=0, state IDLE; a new start completes normally.
- ENC_BINDER_MASK_EN, ch_mask=4'b1010, level_hv=16'h0001, shifts {1,2,3,17} -> shifted_hv={0000,0004,0000,0002}.
